// File: rtl/stack_unit_if.sv
// Stack request/response bundle between the CPU control path and the stack unit.
interface stack_unit_if #(
    parameter int unsigned DATA_W = 8
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output push, output pop, output wdata, input rdata, input rvalid);
    modport slave  (input push, input pop, input wdata, output rdata, output rvalid);
endinterface

// File: rtl/stack_unit.sv
// Hardware LIFO stack: push/pop/replace with registered pop data and sticky misuse flags.
module stack_unit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    stack_unit_if.slave       bus,
    input  logic              err_clr,
    output logic [DATA_W-1:0] top,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);
    localparam int unsigned SP_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_m1;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  wr_idx;
    logic              is_empty;
    logic              is_full;

    // Pointer decode; sp is the occupancy, so the top lives at sp-1.
    always_comb begin
        is_empty = (sp == '0);
        is_full  = (sp == SP_W'(DEPTH));
        sp_m1    = sp - SP_W'(1);
        top_idx  = sp_m1[PTR_W-1:0];
        wr_idx   = sp[PTR_W-1:0];
    end

    assign top   = is_empty ? '0 : mem[top_idx];
    assign count = sp;
    assign empty = is_empty;
    assign full  = is_full;

    // Storage carries no reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (bus.push && !bus.pop && !is_full) begin
                mem[wr_idx] <= bus.wdata;
            end else if (bus.push && bus.pop && !is_empty) begin
                mem[top_idx] <= bus.wdata;
            end
        end
    end

    // Pointer, read port and flags; an error event in the err_clr cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp         <= '0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            bus.rvalid <= 1'b0;
            if (err_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (bus.push && bus.pop) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= is_empty ? bus.wdata : mem[top_idx];
            end else if (bus.push) begin
                if (is_full) begin
                    overflow <= 1'b1;
                end else begin
                    sp <= sp + SP_W'(1);
                end
            end else if (bus.pop) begin
                if (is_empty) begin
                    underflow <= 1'b1;
                end else begin
                    bus.rdata  <= mem[top_idx];
                    bus.rvalid <= 1'b1;
                    sp         <= sp_m1;
                end
            end
        end
    end
endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware LIFO stack for the 8-bit CPU. It services the control unit's stack write enable (push) and stack read enable (pop) strobes: push data arrives from the register file, and popped data returns on a registered read port into the register write-back path. It is the responder side of the CPU's stack interface. It tracks occupancy, exposes the current top entry combinationally, and reports misuse through sticky overflow/underflow flags that software can clear.

## Interface
- DATA_W, 8, width of each stack entry
- DEPTH, 8, number of entries; power of two, at least 2
- PTR_W, log2(DEPTH), width of the storage index (derived, not overridden)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- push  input  1  push request (stack write enable)
- pop  input  1  pop request (stack read enable)
- wdata  input  DATA_W  data to push
- err_clr  input  1  clears both sticky error flags
- rdata  output  DATA_W  popped data, registered
- rvalid  output  1  one-cycle strobe qualifying rdata
- top  output  DATA_W  current top entry, combinational from storage; 0 when empty
- count  output  PTR_W+1  number of valid entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky; set when a push is dropped
- underflow  output  1  sticky; set when a pop finds the stack empty

## Operation
- One clock domain. Reset is synchronous and active-high.
- Storage is DEPTH × DATA_W registers, not reset. A stack pointer sp (PTR_W+1 bits) equals count.
- Push only, not full: mem[sp] <= wdata; sp <= sp+1.
- Push only, full: the write is dropped; sp is unchanged; overflow <= 1.
- Pop only, not empty: rdata <= mem[sp-1]; rvalid <= 1; sp <= sp-1.
- Pop only, empty: rdata holds its previous value; rvalid <= 0; underflow <= 1.
- Push and pop in the same cycle, not empty: replace the top. rdata <= mem[sp-1] (the old top); mem[sp-1] <= wdata; rvalid <= 1; sp is unchanged. This is legal when full, and no flag is set.
- Push and pop in the same cycle, empty: pass-through. rdata <= wdata; rvalid <= 1; sp stays 0; no storage write; no flag is set.
- err_clr clears both flags. If an error event occurs in the same cycle as err_clr, the event wins and its flag is set.
- Error flags never block operation; legal requests continue normally while a flag is set.
- empty, full and top are decoded combinationally from sp. top = mem[sp-1] when sp != 0, else 0.

## Timing
- Reset values: rdata=0, rvalid=0, count=0, empty=1, full=0, top=0, overflow=0, underflow=0.
- rst overrides any concurrent push, pop or err_clr. In-flight rvalid is cleared, and contents are logically discarded (sp=0).
- Push latency: count, top and full update on the clock edge after push is sampled.
- Pop latency: rdata/rvalid are valid exactly 1 cycle after pop is sampled. rvalid is high for one cycle per accepted pop; back-to-back pops give back-to-back rvalid.
- Flags assert 1 cycle after the offending request.
- No handshake back-pressure: every request is resolved in the cycle it is sampled.
- Pointer never wraps: sp saturates at 0 and DEPTH via the drop rules above.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop ×3 -> rdata 0x33, 0x22, 0x11 on consecutive rvalid cycles; count 3→0; empty=1 at the end.
- Fill with DEPTH pushes (0x01..0x08), then push 0xAA -> full=1, count=8, overflow=1 next cycle, top stays 0x08; pop -> rdata=0x08.
- Pop on an empty stack -> rvalid=0, rdata unchanged, underflow=1. Next, assert err_clr with another empty pop in the same cycle -> underflow remains 1. Then err_clr alone -> underflow=0.
- Stack holds [0x05, 0x06]; push 0x77 with pop -> rdata=0x06, rvalid=1, count=2, top=0x77. Empty stack, push 0x42 with pop -> rdata=0x42, rvalid=1, count=0, no flags.
- Push 0x10, 0x20, then assert rst in the same cycle as a pop -> next cycle rvalid=0, count=0, top=0, flags 0; a subsequent pop sets underflow.
